// File: rtl/out_display_if.sv
// out_display_if: output-register value in, 7-segment scan and busy flag out.
// master drives out_val; slave (the display driver) drives seg/an/busy.
interface out_display_if;
  logic [15:0] out_val;
  logic [6:0]  seg;
  logic [4:0]  an;
  logic        busy;

  modport master (
    output out_val,
    input  seg,
    input  an,
    input  busy
  );

  modport slave (
    input  out_val,
    output seg,
    output an,
    output busy
  );
endinterface

// File: rtl/out_display.sv
// out_display: double-dabble BCD conversion plus 5-digit 7-seg scan driver.
// Define OUT_DISPLAY_BLANK_EN for leading-zero blanking of digits 4..1.
module out_display #(
  parameter int REFRESH_DIV = 1000
) (
  input logic         clk,
  input logic         rst,
  out_display_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LOAD
  } state_t;

  state_t      state_q;
  logic [15:0] last_q;
  logic [35:0] shreg_q;
  logic [4:0]  iter_q;
  logic [19:0] disp_q;
  logic [RW-1:0] ref_q;
  logic [2:0]  idx_q;
  logic        busy_q;
  logic [6:0]  seg_q;
  logic [4:0]  an_q;

  logic [35:0] adj;
  logic [35:0] dab_d;
  logic [3:0]  nib;
  logic [4:0]  blank;
  logic        blank_sel;
  logic [6:0]  seg_d;
  logic [4:0]  an_d;

  function automatic logic [6:0] dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // one double-dabble step: correct nibbles >=5, then shift
  always_comb begin
    adj = shreg_q;
    for (int k = 0; k < 5; k++) begin
      if (shreg_q[16+4*k +: 4] >= 4'd5)
        adj[16+4*k +: 4] = shreg_q[16+4*k +: 4] + 4'd3;
    end
    dab_d = adj << 1;
  end

  always_comb begin
    blank = '0;
`ifdef OUT_DISPLAY_BLANK_EN
    blank[4] = (disp_q[19:16] == 4'd0);
    blank[3] = blank[4] && (disp_q[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_q[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_q[7:4] == 4'd0);
`endif
    nib = 4'd0;
    blank_sel = 1'b0;
    case (idx_q)
      3'd0: begin nib = disp_q[3:0];   blank_sel = blank[0]; end
      3'd1: begin nib = disp_q[7:4];   blank_sel = blank[1]; end
      3'd2: begin nib = disp_q[11:8];  blank_sel = blank[2]; end
      3'd3: begin nib = disp_q[15:12]; blank_sel = blank[3]; end
      3'd4: begin nib = disp_q[19:16]; blank_sel = blank[4]; end
      default: begin nib = 4'd0; blank_sel = 1'b1; end
    endcase
    seg_d = blank_sel ? 7'h7F : dec(nib);
    an_d  = ~(5'b00001 << idx_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= '0;
      shreg_q <= '0;
      iter_q  <= '0;
      disp_q  <= '0;
      ref_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 5'h1F;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (ref_q == RW'(REFRESH_DIV - 1)) begin
        ref_q <= '0;
        idx_q <= (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
      end else begin
        ref_q <= ref_q + RW'(1);
      end
      case (state_q)
        IDLE: begin
          if (bus.out_val != last_q) begin
            last_q  <= bus.out_val;
            shreg_q <= {20'd0, bus.out_val};
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          shreg_q <= dab_d;
          iter_q  <= iter_q + 5'd1;
          if (iter_q == 5'd15)
            state_q <= LOAD;
        end
        LOAD: begin
          disp_q  <= shreg_q[35:16];
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.seg  = seg_q;
  assign bus.an   = an_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_out_display.sv
// tb_out_display: directed scoreboard bench for out_display.
// Expected digits come from decimal arithmetic on the driven value.
module tb_out_display;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   exp_q[$];

  out_display_if bus ();

  out_display #(
    .REFRESH_DIV(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int v, input int k);
    int p;
    int d;
    logic [6:0] s;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    d = (v / p) % 10;
    case (d)
      0: s = 7'h40;
      1: s = 7'h79;
      2: s = 7'h24;
      3: s = 7'h30;
      4: s = 7'h19;
      5: s = 7'h12;
      6: s = 7'h02;
      7: s = 7'h78;
      8: s = 7'h00;
      default: s = 7'h10;
    endcase
`ifdef OUT_DISPLAY_BLANK_EN
    if (k >= 1 && v < p) s = 7'h7F;
`endif
    return s;
  endfunction

  function automatic int idx_of(input logic [4:0] an);
    case (an)
      5'h1E: return 0;
      5'h1D: return 1;
      5'h1B: return 2;
      5'h17: return 3;
      5'h0F: return 4;
      default: return -1;
    endcase
  endfunction

  // one scanned digit, sampled at the current negedge
  task automatic digit_chk(input string tag, input int v);
    int k;
    k = idx_of(bus.an);
    if (k < 0) chk({tag, "_an"}, {27'd0, bus.an}, 32'h1E);
    else chk(tag, {25'd0, bus.seg}, {25'd0, seg_of(v, k)});
  endtask

  task automatic scan_chk(input string tag, input int v);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      digit_chk(tag, v);
    end
  endtask

  // count edges from here until busy is seen low
  task automatic wait_done(inout int cnt);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cnt++;
      if (!bus.busy) return;
    end
    chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_conv(input string tag, input logic [15:0] v);
    int cnt;
    int e;
    @(negedge clk);
    bus.out_val = v;
    exp_q.push_back(int'(v));
    cnt = 0;
    wait_done(cnt);
    chk({tag, "_lat"}, cnt, 32'd18);
    e = exp_q.pop_front();
    scan_chk({tag, "_seg"}, e);
  endtask

  initial begin
    int cnt;
    int e;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.out_val = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_an", {27'd0, bus.an}, 32'h1F);
    chk("rst_seg", {25'd0, bus.seg}, 32'h7F);
    rst = 1'b0;

    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk("idle_an", {27'd0, bus.an},
          {27'd0, ~(5'b00001 << (((n - 1) / 4) % 5))});
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      digit_chk("idle_seg", 0);
    end

    run_conv("v1234", 16'h04D2);
    run_conv("vmax", 16'hFFFF);
    run_conv("v42", 16'd42);

    @(negedge clk);
    bus.out_val = 16'd100;
    exp_q.push_back(100);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt++;
    end
    bus.out_val = 16'd200;
    exp_q.push_back(200);
    wait_done(cnt);
    chk("mid_lat1", cnt, 32'd18);
    e = exp_q.pop_front();
    @(negedge clk);
    cnt++;
    chk("mid_restart", {31'd0, bus.busy}, 32'd1);
    digit_chk("mid_seg100", e);
    wait_done(cnt);
    chk("mid_lat2", cnt, 32'd36);
    e = exp_q.pop_front();
    scan_chk("mid_seg200", e);

    @(negedge clk);
    bus.out_val = 16'd1234;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_an", {27'd0, bus.an}, 32'h1F);
    chk("mrst_seg", {25'd0, bus.seg}, 32'h7F);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(1234);
    cnt = 0;
    @(negedge clk);
    cnt++;
    chk("mrst_an0", {27'd0, bus.an}, 32'h1E);
    chk("mrst_disp0", {25'd0, bus.seg}, {25'd0, seg_of(0, 0)});
    chk("mrst_busy1", {31'd0, bus.busy}, 32'd1);
    wait_done(cnt);
    chk("mrst_lat", cnt, 32'd18);
    e = exp_q.pop_front();
    scan_chk("mrst_seg", e);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
